// File: rtl/nvdla_glb_intr_ctrl_if.sv
// Signal bundle between the engines/software register file and the global done-interrupt controller.
interface nvdla_glb_intr_ctrl_if #(
    parameter int NUM_SRC = 6,
    parameter int CNT_W   = 4,
    parameter int TO_W    = 16
);
    logic [2*NUM_SRC-1:0] done_pd;
    logic [2*NUM_SRC-1:0] mask;
    logic [2*NUM_SRC-1:0] wr_data;
    logic                 wr_clr_vld;
    logic                 wr_set_vld;
    logic                 ovf_clr_vld;
    logic [CNT_W-1:0]     cfg_coal_thresh;
    logic [TO_W-1:0]      cfg_coal_timeout;
    logic [2*NUM_SRC-1:0] status;
    logic [2*NUM_SRC-1:0] ovf;
    logic [CNT_W-1:0]     pending_cnt;
    logic                 core_intr;

    modport master (
        output done_pd, mask, wr_data, wr_clr_vld, wr_set_vld, ovf_clr_vld,
               cfg_coal_thresh, cfg_coal_timeout,
        input  status, ovf, pending_cnt, core_intr
    );

    modport slave (
        input  done_pd, mask, wr_data, wr_clr_vld, wr_set_vld, ovf_clr_vld,
               cfg_coal_thresh, cfg_coal_timeout,
        output status, ovf, pending_cnt, core_intr
    );
endinterface

// File: rtl/nvdla_glb_intr_ctrl.sv
// NVDLA global done-interrupt controller: sticky ping/pong done status, overflow flags, level interrupt.
// Optional interrupt coalescing is built when NVDLA_GLB_INTR_COALESCE_EN is defined.
module nvdla_glb_intr_ctrl #(
    parameter int NUM_SRC = 6,
    parameter int CNT_W   = 4,
    parameter int TO_W    = 16
) (
    input  logic                   nvdla_core_clk,
    input  logic                   nvdla_core_rstn,
    nvdla_glb_intr_ctrl_if.slave   intr
);
    localparam int N = 2 * NUM_SRC;

    logic [N-1:0]     done_q;
    logic [N-1:0]     status_q;
    logic [N-1:0]     ovf_q;
    logic [CNT_W-1:0] pending_cnt_q;
    logic             core_intr_q;

    logic [N-1:0]     st_set;
    logic [N-1:0]     st_clr;
    logic [N-1:0]     ovf_set;
    logic [N-1:0]     ovf_clr;
    logic [N-1:0]     unmasked;

    function automatic logic [CNT_W-1:0] popcnt(input logic [N-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < N; i++) c = c + CNT_W'(v[i]);
        return c;
    endfunction

    // Set beats clear on the same bit; a done that races a clear is not an overflow.
    assign st_set   = done_q | ({N{intr.wr_set_vld}} & intr.wr_data);
    assign st_clr   = {N{intr.wr_clr_vld}} & intr.wr_data;
    assign ovf_set  = done_q & status_q & ~st_clr;
    assign ovf_clr  = {N{intr.ovf_clr_vld}} & intr.wr_data;
    assign unmasked = status_q & ~intr.mask;

    // Stage 0: done capture; stage 1: status/overflow; stage 2: pending count
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            done_q        <= '0;
            status_q      <= '0;
            ovf_q         <= '0;
            pending_cnt_q <= '0;
        end else begin
            done_q        <= intr.done_pd;
            status_q      <= st_set | (status_q & ~st_clr);
            ovf_q         <= ovf_set | (ovf_q & ~ovf_clr);
            pending_cnt_q <= popcnt(unmasked);
        end
    end

`ifdef NVDLA_GLB_INTR_COALESCE_EN
    typedef enum logic [1:0] {IDLE, WAIT, FIRE} coal_state_e;

    coal_state_e      state, state_nxt;
    logic [TO_W-1:0]  tmr, tmr_nxt;
    logic [TO_W:0]    tmr_inc;
    logic [CNT_W-1:0] thr;
    logic             timeout_hit;

    function automatic logic [TO_W-1:0] sat_inc(input logic [TO_W-1:0] v);
        return (&v) ? v : v + TO_W'(1);
    endfunction

    assign thr         = (intr.cfg_coal_thresh == '0) ? CNT_W'(1) : intr.cfg_coal_thresh;
    assign tmr_inc     = {1'b0, tmr} + (TO_W+1)'(1);
    assign timeout_hit = (intr.cfg_coal_timeout != '0) && (tmr_inc >= {1'b0, intr.cfg_coal_timeout});

    always_comb begin
        state_nxt = state;
        tmr_nxt   = '0;
        case (state)
            IDLE: begin
                if (pending_cnt_q >= thr)        state_nxt = FIRE;
                else if (pending_cnt_q != '0)    state_nxt = WAIT;
            end
            WAIT: begin
                tmr_nxt = sat_inc(tmr);
                if (pending_cnt_q == '0)         state_nxt = IDLE;
                else if (pending_cnt_q >= thr)   state_nxt = FIRE;
                else if (timeout_hit)            state_nxt = FIRE;
            end
            FIRE: begin
                if (pending_cnt_q == '0)         state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage 3: coalescing state; the interrupt flop tracks the next state so it lines up with FIRE
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state       <= IDLE;
            tmr         <= '0;
            core_intr_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            tmr         <= tmr_nxt;
            core_intr_q <= (state_nxt == FIRE);
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{intr.cfg_coal_thresh, intr.cfg_coal_timeout};

    // Stage 2: plain level interrupt from unmasked status
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) core_intr_q <= 1'b0;
        else                  core_intr_q <= |unmasked;
    end
`endif

    assign intr.status      = status_q;
    assign intr.ovf         = ovf_q;
    assign intr.pending_cnt = pending_cnt_q;
    assign intr.core_intr   = core_intr_q;
endmodule

// File: tb/tb_nvdla_glb_intr_ctrl.sv
// Directed bench for nvdla_glb_intr_ctrl; coalescing cases run when NVDLA_GLB_INTR_COALESCE_EN is defined.
module tb_nvdla_glb_intr_ctrl;
    localparam int NUM_SRC = 6;
    localparam int CNT_W   = 4;
    localparam int TO_W    = 16;

    logic nvdla_core_clk  = 1'b0;
    logic nvdla_core_rstn = 1'b0;
    int   total = 0;
    int   bad   = 0;

    nvdla_glb_intr_ctrl_if #(.NUM_SRC(NUM_SRC), .CNT_W(CNT_W), .TO_W(TO_W)) intr ();

    nvdla_glb_intr_ctrl #(.NUM_SRC(NUM_SRC), .CNT_W(CNT_W), .TO_W(TO_W)) dut (
        .nvdla_core_clk  (nvdla_core_clk),
        .nvdla_core_rstn (nvdla_core_rstn),
        .intr            (intr)
    );

    always #5 nvdla_core_clk = ~nvdla_core_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge nvdla_core_clk);
        #1;
    endtask

    task automatic pulse(input logic [11:0] v);
        intr.done_pd = v;
        tick();
        intr.done_pd = '0;
    endtask

    task automatic sw_clr(input logic [11:0] v);
        intr.wr_clr_vld = 1'b1;
        intr.wr_data    = v;
        tick();
        intr.wr_clr_vld = 1'b0;
        intr.wr_data    = '0;
    endtask

    initial begin
        intr.done_pd          = '0;
        intr.mask             = '0;
        intr.wr_data          = '0;
        intr.wr_clr_vld       = 1'b0;
        intr.wr_set_vld       = 1'b0;
        intr.ovf_clr_vld      = 1'b0;
        intr.cfg_coal_thresh  = '0;
        intr.cfg_coal_timeout = '0;

        tick();
        tick();
        chk("rst_status", 32'(intr.status), 32'h0);
        chk("rst_ovf", 32'(intr.ovf), 32'h0);
        chk("rst_pend", 32'(intr.pending_cnt), 32'h0);
        chk("rst_intr", 32'(intr.core_intr), 32'h0);
        nvdla_core_rstn = 1'b1;
        tick();

`ifndef NVDLA_GLB_INTR_COALESCE_EN
        // Basic done -> status -> interrupt, then software clear
        pulse(12'h001);
        tick();
        chk("t1_status", 32'(intr.status), 32'h001);
        chk("t1_intr_early", 32'(intr.core_intr), 32'h0);
        tick();
        chk("t1_intr", 32'(intr.core_intr), 32'h1);
        chk("t1_pend", 32'(intr.pending_cnt), 32'h1);
        chk("t1_ovf", 32'(intr.ovf), 32'h0);
        sw_clr(12'h001);
        chk("t1_clr_status", 32'(intr.status), 32'h0);
        chk("t1_clr_intr_hold", 32'(intr.core_intr), 32'h1);
        tick();
        chk("t1_clr_intr", 32'(intr.core_intr), 32'h0);

        // Masked source updates status but not the interrupt
        intr.mask = 12'h002;
        pulse(12'h002);
        tick();
        tick();
        chk("t2_status", 32'(intr.status), 32'h002);
        chk("t2_intr_masked", 32'(intr.core_intr), 32'h0);
        chk("t2_pend_masked", 32'(intr.pending_cnt), 32'h0);
        intr.mask = '0;
        tick();
        chk("t2_intr_unmask", 32'(intr.core_intr), 32'h1);
        chk("t2_pend_unmask", 32'(intr.pending_cnt), 32'h1);
        intr.mask = 12'hfff;
        tick();
        chk("t2_intr_remask", 32'(intr.core_intr), 32'h0);
        intr.mask = '0;
        sw_clr(12'hfff);
        tick();
        tick();
`endif

        // Overflow set, clear, and the clear-races-done case
        pulse(12'h010);
        tick();
        pulse(12'h010);
        tick();
        chk("t3_ovf_set", 32'(intr.ovf), 32'h010);
        chk("t3_status", 32'(intr.status), 32'h010);
        intr.ovf_clr_vld = 1'b1;
        intr.wr_data     = 12'h010;
        tick();
        intr.ovf_clr_vld = 1'b0;
        intr.wr_data     = '0;
        chk("t3_ovf_clr", 32'(intr.ovf), 32'h0);
        intr.done_pd = 12'h010;
        tick();
        intr.done_pd    = '0;
        intr.wr_clr_vld = 1'b1;
        intr.wr_data    = 12'h010;
        tick();
        intr.wr_clr_vld = 1'b0;
        intr.wr_data    = '0;
        chk("t3_race_status", 32'(intr.status), 32'h010);
        chk("t3_race_ovf", 32'(intr.ovf), 32'h0);
        intr.done_pd = 12'h010;
        tick();
        intr.done_pd     = '0;
        intr.ovf_clr_vld = 1'b1;
        intr.wr_data     = 12'h010;
        tick();
        intr.ovf_clr_vld = 1'b0;
        intr.wr_data     = '0;
        chk("t3_ovf_setwins", 32'(intr.ovf), 32'h010);
        intr.wr_clr_vld  = 1'b1;
        intr.ovf_clr_vld = 1'b1;
        intr.wr_data     = 12'hfff;
        tick();
        intr.wr_clr_vld  = 1'b0;
        intr.ovf_clr_vld = 1'b0;
        intr.wr_data     = '0;
        chk("t3_clrall_status", 32'(intr.status), 32'h0);
        chk("t3_clrall_ovf", 32'(intr.ovf), 32'h0);

        // Simultaneous set and clear: set wins
        intr.wr_set_vld = 1'b1;
        intr.wr_clr_vld = 1'b1;
        intr.wr_data    = 12'h800;
        tick();
        intr.wr_set_vld = 1'b0;
        intr.wr_clr_vld = 1'b0;
        intr.wr_data    = '0;
        chk("t4_setclr", 32'(intr.status), 32'h800);
        tick();
        chk("t4_pend", 32'(intr.pending_cnt), 32'h1);
        sw_clr(12'hfff);
        tick();
        tick();
        tick();

`ifndef NVDLA_GLB_INTR_COALESCE_EN
        // Asynchronous reset mid-operation
        pulse(12'h020);
        tick();
        tick();
        chk("t5_intr_pre", 32'(intr.core_intr), 32'h1);
        #2;
        nvdla_core_rstn = 1'b0;
        #1;
        chk("t5_rst_status", 32'(intr.status), 32'h0);
        chk("t5_rst_intr", 32'(intr.core_intr), 32'h0);
        chk("t5_rst_pend", 32'(intr.pending_cnt), 32'h0);
        tick();
        nvdla_core_rstn = 1'b1;
        tick();
`else
        // Count threshold coalescing
        intr.cfg_coal_thresh  = 4'd3;
        intr.cfg_coal_timeout = '0;
        pulse(12'h001);
        repeat (4) tick();
        chk("c1_pend1", 32'(intr.pending_cnt), 32'h1);
        chk("c1_intr1", 32'(intr.core_intr), 32'h0);
        pulse(12'h004);
        repeat (4) tick();
        chk("c1_pend2", 32'(intr.pending_cnt), 32'h2);
        chk("c1_intr2", 32'(intr.core_intr), 32'h0);
        pulse(12'h010);
        tick();
        tick();
        chk("c1_pend3", 32'(intr.pending_cnt), 32'h3);
        chk("c1_intr3_early", 32'(intr.core_intr), 32'h0);
        tick();
        chk("c1_intr_fire", 32'(intr.core_intr), 32'h1);
        sw_clr(12'h001);
        tick();
        tick();
        chk("c1_pend_after_clr", 32'(intr.pending_cnt), 32'h2);
        chk("c1_intr_hold", 32'(intr.core_intr), 32'h1);
        sw_clr(12'hfff);
        tick();
        chk("c1_intr_drop_early", 32'(intr.core_intr), 32'h1);
        tick();
        chk("c1_intr_drop", 32'(intr.core_intr), 32'h0);
        tick();

        // Timeout coalescing and reset in WAIT
        intr.cfg_coal_thresh  = 4'd4;
        intr.cfg_coal_timeout = 16'd10;
        pulse(12'h001);
        tick();
        tick();
        tick();
        chk("c2_state_wait", 32'(dut.state), 32'h1);
        repeat (9) tick();
        chk("c2_intr_early", 32'(intr.core_intr), 32'h0);
        tick();
        chk("c2_intr_timeout", 32'(intr.core_intr), 32'h1);
        sw_clr(12'hfff);
        tick();
        tick();
        pulse(12'h004);
        tick();
        tick();
        tick();
        tick();
        tick();
        tick();
        chk("c2_tmr_run", 32'(dut.tmr), 32'h3);
        #2;
        nvdla_core_rstn = 1'b0;
        #1;
        chk("c2_rst_intr", 32'(intr.core_intr), 32'h0);
        chk("c2_rst_tmr", 32'(dut.tmr), 32'h0);
        chk("c2_rst_status", 32'(intr.status), 32'h0);
        chk("c2_rst_state", 32'(dut.state), 32'h0);
        tick();
        nvdla_core_rstn = 1'b1;
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
